i2c_x12_seq: RTL and testbench

- Sequences byte-level register transactions on the 12-channel I2C crossbar on behalf of one client.
- Acts as a WISHBONE master: it plugs into one crossbar slave port (wb0 or wb1) and drives the per-bus OpenCores i2c_master_top register file.
- After reset it enables all 12 cores.
- After that it accepts single-register read/write commands {bus, device, register, data}. For each command it runs the full START/address/data/STOP sequence by polling status, then returns one response.

---
 rtl/i2c_x12_seq.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_i2c_x12_seq.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_x12_seq.sv
// i2c_x12_seq
// Runs single-register read/write transactions for one client on the
// 12-channel I2C crossbar. The block is a WISHBONE master on one crossbar
// slave port and drives the OpenCores i2c_master_top register files.
// After reset it programs the prescaler of every core and enables it.
// It then accepts one command at a time, runs the START/address/data/STOP
// byte phases by polling SR, and returns one response strobe.
//
// Ports
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o   command handshake
//   cmd_bus_i/dev/reg/rnw/wdata  target bus, 7-bit slave address, pointer
//                             byte, read-not-write, write data
//   rsp_valid_o               one-cycle response strobe
//   rsp_data_o/nack/err       read byte, slave NACK, WB error/timeout/bad bus
//   wb_*                      WISHBONE master, adr = {bus[3:0], reg[2:0]}
module i2c_x12_seq #(
   parameter logic [15:0] PRESCALE   = 16'h00C7,
   parameter int          NUM_BUS    = 12,
   parameter int          POLL_LIMIT = 4096
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [3:0] cmd_bus_i,
   input  logic [6:0] cmd_dev_i,
   input  logic [7:0] cmd_reg_i,
   input  logic       cmd_rnw_i,
   input  logic [7:0] cmd_wdata_i,
   output logic       rsp_valid_o,
   output logic [7:0] rsp_data_o,
   output logic       rsp_nack_o,
   output logic       rsp_err_o,
   output logic       wb_cyc_o,
   output logic       wb_stb_o,
   output logic       wb_we_o,
   output logic [6:0] wb_adr_o,
   output logic [7:0] wb_dat_o,
   input  logic [7:0] wb_dat_i,
   input  logic       wb_ack_i,
   input  logic       wb_err_i,
   input  logic       wb_rty_i
);

   localparam int            PW        = $clog2(POLL_LIMIT + 1);
   localparam logic [3:0]    LAST_BUS  = 4'(NUM_BUS - 1);
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);
   localparam logic [2:0]    A_TXR     = 3'd3;
   localparam logic [2:0]    A_CR      = 3'd4;

   typedef enum logic [3:0] {
      S_INIT, S_IDLE, S_TXR, S_CR, S_POLL, S_RXR,
      S_NACK_CR, S_NACK_POLL, S_ABORT, S_RESP
   } state_t;

   state_t        state_q, state_d;
   logic          gap_q, gap_d;
   logic [3:0]    bus_q, bus_d;
   logic [1:0]    init_idx_q, init_idx_d;
   logic [1:0]    phase_q, phase_d;
   logic [PW-1:0] poll_q, poll_d;
   logic [6:0]    dev_q, dev_d;
   logic [7:0]    reg_q, reg_d;
   logic          rnw_q, rnw_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [7:0]    rsp_data_q, rsp_data_d;
   logic          rsp_nack_q, rsp_nack_d;
   logic          rsp_err_q, rsp_err_d;

   logic          acc_active, acc_we;
   logic [2:0]    acc_reg;
   logic [7:0]    acc_dat;
   logic          hit_ack, hit_err, hit_rty;
   logic          last_phase, check_ack, tip, rxack;

   // All state lives here; reset clears everything and gap_q=1 keeps the
   // bus idle until the first INIT write is issued one cycle after release.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_INIT;
         gap_q      <= 1'b1;
         bus_q      <= '0;
         init_idx_q <= '0;
         phase_q    <= '0;
         poll_q     <= '0;
         dev_q      <= '0;
         reg_q      <= '0;
         rnw_q      <= 1'b0;
         wdata_q    <= '0;
         rsp_data_q <= '0;
         rsp_nack_q <= 1'b0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         bus_q      <= bus_d;
         init_idx_q <= init_idx_d;
         phase_q    <= phase_d;
         poll_q     <= poll_d;
         dev_q      <= dev_d;
         reg_q      <= reg_d;
         rnw_q      <= rnw_d;
         wdata_q    <= wdata_d;
         rsp_data_q <= rsp_data_d;
         rsp_nack_q <= rsp_nack_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   // Decode which register access the current state performs. Phase 2 of a
   // read is the repeated-start address; phase 3 is the RD|NACK|STO byte.
   always_comb begin
      acc_active = 1'b0;
      acc_we     = 1'b0;
      acc_reg    = A_CR;
      acc_dat    = 8'h00;
      case (state_q)
         S_INIT: begin
            acc_active = 1'b1;
            acc_we     = 1'b1;
            acc_reg    = {1'b0, init_idx_q};
            case (init_idx_q)
               2'd0:    acc_dat = PRESCALE[7:0];
               2'd1:    acc_dat = PRESCALE[15:8];
               default: acc_dat = 8'h80;
            endcase
         end
         S_TXR: begin
            acc_active = 1'b1;
            acc_we     = 1'b1;
            acc_reg    = A_TXR;
            case (phase_q)
               2'd0:    acc_dat = {dev_q, 1'b0};
               2'd1:    acc_dat = reg_q;
               default: acc_dat = rnw_q ? {dev_q, 1'b1} : wdata_q;
            endcase
         end
         S_CR: begin
            acc_active = 1'b1;
            acc_we     = 1'b1;
            case (phase_q)
               2'd0:    acc_dat = 8'h90;
               2'd1:    acc_dat = 8'h10;
               2'd2:    acc_dat = rnw_q ? 8'h90 : 8'h50;
               default: acc_dat = 8'h68;
            endcase
         end
         S_POLL, S_NACK_POLL: acc_active = 1'b1;
         S_RXR: begin
            acc_active = 1'b1;
            acc_reg    = A_TXR;
         end
         S_NACK_CR, S_ABORT: begin
            acc_active = 1'b1;
            acc_we     = 1'b1;
            acc_dat    = 8'h40;
         end
         default: acc_active = 1'b0;
      endcase
   end

   // The bus is driven straight from registered state so an asynchronous
   // reset drops cyc/stb immediately. gap_q forces one idle cycle after every
   // ack/err/rty so the crossbar arbiter can release or re-grant.
   assign wb_cyc_o    = acc_active & ~gap_q;
   assign wb_stb_o    = wb_cyc_o;
   assign wb_we_o     = wb_cyc_o & acc_we;
   assign wb_adr_o    = wb_cyc_o ? {bus_q, acc_reg} : 7'h00;
   assign wb_dat_o    = wb_we_o ? acc_dat : 8'h00;

   assign hit_ack     = wb_cyc_o & wb_ack_i;
   assign hit_err     = wb_cyc_o & wb_err_i & ~wb_ack_i;
   assign hit_rty     = wb_cyc_o & wb_rty_i & ~wb_ack_i & ~wb_err_i;

   assign last_phase  = rnw_q ? (phase_q == 2'd3) : (phase_q == 2'd2);
   assign check_ack   = !(rnw_q && phase_q == 2'd3);
   assign tip         = wb_dat_i[1];
   assign rxack       = wb_dat_i[7];

   assign cmd_ready_o = (state_q == S_IDLE);
   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_data_o  = rsp_valid_o ? rsp_data_q : 8'h00;
   assign rsp_nack_o  = rsp_valid_o & rsp_nack_q;
   assign rsp_err_o   = rsp_valid_o & rsp_err_q;

   // Sequencer: every access state waits for its handshake, a retry just
   // stays put (the same access is reissued after the gap cycle).
   always_comb begin
      state_d    = state_q;
      gap_d      = hit_ack | hit_err | hit_rty;
      bus_d      = bus_q;
      init_idx_d = init_idx_q;
      phase_d    = phase_q;
      poll_d     = poll_q;
      dev_d      = dev_q;
      reg_d      = reg_q;
      rnw_d      = rnw_q;
      wdata_d    = wdata_q;
      rsp_data_d = rsp_data_q;
      rsp_nack_d = rsp_nack_q;
      rsp_err_d  = rsp_err_q;
      case (state_q)
         S_INIT: begin
            if (hit_ack || hit_err) begin
               if (hit_err || init_idx_q == 2'd2) begin
                  init_idx_d = 2'd0;
                  if (bus_q == LAST_BUS) state_d = S_IDLE;
                  else                   bus_d   = bus_q + 4'd1;
               end else begin
                  init_idx_d = init_idx_q + 2'd1;
               end
            end
         end
         S_IDLE: begin
            if (cmd_valid_i) begin
               bus_d      = cmd_bus_i;
               dev_d      = cmd_dev_i;
               reg_d      = cmd_reg_i;
               rnw_d      = cmd_rnw_i;
               wdata_d    = cmd_wdata_i;
               phase_d    = 2'd0;
               rsp_data_d = 8'h00;
               rsp_nack_d = 1'b0;
               rsp_err_d  = cmd_bus_i > LAST_BUS;
               state_d    = (cmd_bus_i > LAST_BUS) ? S_RESP : S_TXR;
            end
         end
         S_TXR: begin
            if (hit_ack)      state_d = S_CR;
            else if (hit_err) state_d = S_ABORT;
         end
         S_CR, S_NACK_CR: begin
            if (hit_ack) begin
               poll_d  = '0;
               state_d = (state_q == S_CR) ? S_POLL : S_NACK_POLL;
            end else if (hit_err) begin
               state_d = S_ABORT;
            end
         end
         S_POLL, S_NACK_POLL: begin
            if (hit_err) begin
               state_d = S_ABORT;
            end else if (hit_ack) begin
               if (tip) begin
                  if (poll_q == POLL_LAST) state_d = S_ABORT;
                  else                     poll_d  = poll_q + PW'(1);
               end else if (state_q == S_NACK_POLL) begin
                  rsp_nack_d = 1'b1;
                  state_d    = S_RESP;
               end else if (check_ack && rxack) begin
                  state_d = S_NACK_CR;
               end else if (last_phase) begin
                  state_d = rnw_q ? S_RXR : S_RESP;
               end else begin
                  phase_d = phase_q + 2'd1;
                  state_d = (rnw_q && phase_q == 2'd2) ? S_CR : S_TXR;
               end
            end
         end
         S_RXR: begin
            if (hit_ack) begin
               rsp_data_d = wb_dat_i;
               state_d    = S_RESP;
            end else if (hit_err) begin
               state_d = S_ABORT;
            end
         end
         S_ABORT: begin
            // Best-effort STOP: an error on this write is not reported twice.
            if (hit_ack || hit_err) begin
               rsp_data_d = 8'h00;
               rsp_nack_d = 1'b0;
               rsp_err_d  = 1'b1;
               state_d    = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_INIT;
      endcase
   end

endmodule

// File: tb/tb_i2c_x12_seq.sv
// tb_i2c_x12_seq
// Self-checking bench for i2c_x12_seq. A behavioural WISHBONE slave stands
// in for the twelve i2c_master_top cores behind the crossbar. Expected bus
// accesses and responses are queued when a command is issued and compared
// when the design produces them.
module tb_i2c_x12_seq;

   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b0;
   logic       cmd_valid_i = 1'b0;
   logic       cmd_ready_o;
   logic [3:0] cmd_bus_i = '0;
   logic [6:0] cmd_dev_i = '0;
   logic [7:0] cmd_reg_i = '0;
   logic       cmd_rnw_i = 1'b0;
   logic [7:0] cmd_wdata_i = '0;
   logic       rsp_valid_o;
   logic [7:0] rsp_data_o;
   logic       rsp_nack_o;
   logic       rsp_err_o;
   logic       wb_cyc_o, wb_stb_o, wb_we_o;
   logic [6:0] wb_adr_o;
   logic [7:0] wb_dat_o;
   logic [7:0] wb_dat_i = '0;
   logic       wb_ack_i = 1'b0;
   logic       wb_err_i = 1'b0;
   logic       wb_rty_i = 1'b0;

   typedef struct packed { logic we; logic [6:0] adr; logic [7:0] dat; } acc_t;
   typedef struct packed { logic [7:0] data; logic nack; logic err; } rsp_t;

   acc_t exp_q[$];
   rsp_t rsp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   // Slave model knobs
   int         tip_polls = 1;
   bit         tip_stuck = 1'b0;
   int         nack_cr = 0;
   logic [7:0] rxr_val = 8'h00;
   int         rty_at = 0;
   int         err_at = 0;
   int         acc_num = 0;
   int         cr_num = 0;
   int         sr_cnt = 0;
   int         sr_reads = 0;
   bit         rxack_flag = 1'b0;

   i2c_x12_seq #(.PRESCALE(16'h00C7), .NUM_BUS(12), .POLL_LIMIT(8)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_bus_i(cmd_bus_i), .cmd_dev_i(cmd_dev_i), .cmd_reg_i(cmd_reg_i),
      .cmd_rnw_i(cmd_rnw_i), .cmd_wdata_i(cmd_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
      .rsp_nack_o(rsp_nack_o), .rsp_err_o(rsp_err_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
   );

   always #5 clk_i = ~clk_i;

   // Watchdog so a stuck design can never hang the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "[TB] watchdog");
   end

   // WISHBONE slave: answers each access one cycle after it appears with a
   // single-cycle ack/err/rty, and checks the access against the head of the
   // expected queue. A retried access is checked but stays queued.
   initial begin : slave
      acc_t cur;
      forever begin
         @(posedge clk_i);
         #1;
         if (!rst_n_i || wb_ack_i || wb_err_i || wb_rty_i) begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_rty_i = 1'b0;
         end else if (wb_cyc_o && wb_stb_o) begin
            acc_num++;
            cur = {wb_we_o, wb_adr_o, (wb_we_o ? wb_dat_o : 8'h00)};
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL wb_access: got we=%0b adr=%h dat=%h, required no access",
                        cur.we, cur.adr, cur.dat);
            end else begin
               if (cur !== exp_q[0]) begin
                  n_fail++;
                  $display("[TB] FAIL wb_access: got we=%0b adr=%h dat=%h, required we=%0b adr=%h dat=%h",
                           cur.we, cur.adr, cur.dat, exp_q[0].we, exp_q[0].adr, exp_q[0].dat);
               end
               if (acc_num != rty_at) void'(exp_q.pop_front());
            end
            wb_dat_i = 8'h00;
            if (acc_num == rty_at) begin
               wb_rty_i = 1'b1;
            end else if (acc_num == err_at) begin
               wb_err_i = 1'b1;
            end else begin
               wb_ack_i = 1'b1;
               if (wb_we_o && wb_adr_o[2:0] == 3'd4) begin
                  cr_num++;
                  sr_cnt     = 0;
                  rxack_flag = (cr_num == nack_cr);
               end
               if (!wb_we_o && wb_adr_o[2:0] == 3'd4) begin
                  sr_cnt++;
                  sr_reads++;
                  wb_dat_i = {rxack_flag, 5'b00000, (tip_stuck || sr_cnt < tip_polls), 1'b0};
               end
               if (!wb_we_o && wb_adr_o[2:0] == 3'd3) wb_dat_i = rxr_val;
            end
         end
      end
   end

   task automatic push_wr(input logic [6:0] adr, input logic [7:0] dat);
      exp_q.push_back({1'b1, adr, dat});
   endtask

   task automatic push_rd(input logic [6:0] adr, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({1'b0, adr, 8'h00});
   endtask

   task automatic push_init();
      for (int b = 0; b < 12; b++) begin
         push_wr({4'(b), 3'd0}, 8'hC7);
         push_wr({4'(b), 3'd1}, 8'h00);
         push_wr({4'(b), 3'd2}, 8'h80);
      end
   endtask

   task automatic setup_slave(input int polls, input int nack_idx, input int rty_idx, input int err_idx);
      tip_polls = polls;
      nack_cr   = nack_idx;
      rty_at    = rty_idx;
      err_at    = err_idx;
      acc_num   = 0;
      cr_num    = 0;
      sr_cnt    = 0;
      sr_reads  = 0;
   endtask

   task automatic send_cmd(input logic [3:0] bus, input logic [6:0] dev, input logic [7:0] rg,
                           input logic rnw, input logic [7:0] wd, output bit got_ready);
      got_ready = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_i);
         if (cmd_ready_o) begin
            got_ready = 1'b1;
            break;
         end
      end
      if (got_ready) begin
         cmd_bus_i   = bus;
         cmd_dev_i   = dev;
         cmd_reg_i   = rg;
         cmd_rnw_i   = rnw;
         cmd_wdata_i = wd;
         cmd_valid_i = 1'b1;
         @(posedge clk_i);
         #1;
         cmd_valid_i = 1'b0;
      end
   endtask

   task automatic wait_rsp(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk_i);
         if (rsp_valid_o) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   // Runs one command and compares its response and the drained access list.
   task automatic run_cmd(input string name, input logic [3:0] bus, input logic [6:0] dev,
                          input logic [7:0] rg, input logic rnw, input logic [7:0] wd);
      bit   ok, seen;
      rsp_t got, exp;
      send_cmd(bus, dev, rg, rnw, wd, ok);
      seen = 1'b0;
      if (ok) wait_rsp(seen);
      got = {rsp_data_o, rsp_nack_o, rsp_err_o};
      exp = rsp_q.pop_front();
      n_cmp++;
      if (!ok || !seen) begin
         n_fail++;
         $display("[TB] FAIL %s_rsp: got ready=%0b rsp_valid=%0b, required a response", name, ok, seen);
      end else if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s_rsp: got data=%h nack=%0b err=%0b, required data=%h nack=%0b err=%0b",
                  name, got.data, got.nack, got.err, exp.data, exp.nack, exp.err);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL %s_seq: got %0d accesses missing, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      int ready_at;
      $display("[TB] reset and INIT of 12 cores");
      rst_n_i = 1'b0;
      repeat (3) @(negedge clk_i);
      n_cmp++;
      if ({cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_nack_o, rsp_err_o, wb_cyc_o, wb_stb_o,
           wb_we_o, wb_adr_o, wb_dat_o} !== 30'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: got cyc=%0b ready=%0b adr=%h, required all 0",
                  wb_cyc_o, cmd_ready_o, wb_adr_o);
      end
      push_init();
      @(posedge clk_i);
      #2 rst_n_i = 1'b1;
      ready_at = -1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk_i);
         if (cmd_ready_o) begin
            ready_at = i;
            break;
         end
      end
      n_cmp++;
      if (ready_at < 0 || exp_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL init_ready: got ready_cycle=%0d pending=%0d, required ready after all 36 writes",
                  ready_at, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_write();
      $display("[TB] write bus 3 dev 48 reg 01 data 5A");
      setup_slave(5, 0, 0, 0);
      push_wr(7'h1B, 8'h90); push_wr(7'h1C, 8'h90); push_rd(7'h1C, 5);
      push_wr(7'h1B, 8'h01); push_wr(7'h1C, 8'h10); push_rd(7'h1C, 5);
      push_wr(7'h1B, 8'h5A); push_wr(7'h1C, 8'h50); push_rd(7'h1C, 5);
      rsp_q.push_back({8'h00, 1'b0, 1'b0});
      run_cmd("write", 4'd3, 7'h48, 8'h01, 1'b0, 8'h5A);
      @(negedge clk_i);
      n_cmp++;
      if ({rsp_valid_o, cmd_ready_o} !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL rsp_one_cycle: got valid=%0b ready=%0b, required valid=0 ready=1",
                  rsp_valid_o, cmd_ready_o);
      end
   endtask

   task automatic test_read();
      $display("[TB] read bus 11 dev 50 reg 10");
      setup_slave(2, 0, 0, 0);
      rxr_val = 8'hA5;
      push_wr(7'h5B, 8'hA0); push_wr(7'h5C, 8'h90); push_rd(7'h5C, 2);
      push_wr(7'h5B, 8'h10); push_wr(7'h5C, 8'h10); push_rd(7'h5C, 2);
      push_wr(7'h5B, 8'hA1); push_wr(7'h5C, 8'h90); push_rd(7'h5C, 2);
      push_wr(7'h5C, 8'h68); push_rd(7'h5C, 2);
      push_rd(7'h5B, 1);
      rsp_q.push_back({8'hA5, 1'b0, 1'b0});
      run_cmd("read", 4'd11, 7'h50, 8'h10, 1'b1, 8'hFF);
   endtask

   task automatic test_nack();
      $display("[TB] slave NACK on address phase");
      setup_slave(1, 1, 0, 0);
      push_wr(7'h03, 8'h44); push_wr(7'h04, 8'h90); push_rd(7'h04, 1);
      push_wr(7'h04, 8'h40); push_rd(7'h04, 1);
      rsp_q.push_back({8'h00, 1'b1, 1'b0});
      run_cmd("nack", 4'd0, 7'h22, 8'h05, 1'b0, 8'h77);
   endtask

   task automatic test_timeout();
      $display("[TB] TIP stuck, poll limit 8");
      setup_slave(1, 0, 0, 0);
      tip_stuck = 1'b1;
      push_wr(7'h2B, 8'h20); push_wr(7'h2C, 8'h90); push_rd(7'h2C, 8);
      push_wr(7'h2C, 8'h40);
      rsp_q.push_back({8'h00, 1'b0, 1'b1});
      run_cmd("timeout", 4'd5, 7'h10, 8'h02, 1'b0, 8'h11);
      tip_stuck = 1'b0;
      n_cmp++;
      if (sr_reads != 8) begin
         n_fail++;
         $display("[TB] FAIL timeout_polls: got %0d SR reads, required 8", sr_reads);
      end
   endtask

   task automatic test_bad_bus();
      bit ok;
      $display("[TB] illegal bus 12");
      setup_slave(1, 0, 0, 0);
      send_cmd(4'd12, 7'h10, 8'h00, 1'b0, 8'h00, ok);
      @(negedge clk_i);
      n_cmp++;
      if (!ok || {rsp_valid_o, rsp_data_o, rsp_nack_o, rsp_err_o} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL bad_bus_rsp: got valid=%0b data=%h nack=%0b err=%0b, required valid=1 data=00 nack=0 err=1",
                  rsp_valid_o, rsp_data_o, rsp_nack_o, rsp_err_o);
      end
      @(negedge clk_i);
      n_cmp++;
      if ({rsp_valid_o, cmd_ready_o, wb_cyc_o} !== 3'b010) begin
         n_fail++;
         $display("[TB] FAIL bad_bus_after: got valid=%0b ready=%0b cyc=%0b, required 0 1 0",
                  rsp_valid_o, cmd_ready_o, wb_cyc_o);
      end
   endtask

   task automatic test_retry();
      $display("[TB] rty on second access");
      setup_slave(1, 0, 2, 0);
      push_wr(7'h13, 8'h62); push_wr(7'h14, 8'h90); push_rd(7'h14, 1);
      push_wr(7'h13, 8'h07); push_wr(7'h14, 8'h10); push_rd(7'h14, 1);
      push_wr(7'h13, 8'hC3); push_wr(7'h14, 8'h50); push_rd(7'h14, 1);
      rsp_q.push_back({8'h00, 1'b0, 1'b0});
      run_cmd("retry", 4'd2, 7'h31, 8'h07, 1'b0, 8'hC3);
      rty_at = 0;
   endtask

   task automatic test_wb_err();
      $display("[TB] WB err on first TXR write");
      setup_slave(1, 0, 0, 1);
      push_wr(7'h23, 8'h20);
      push_wr(7'h24, 8'h40);
      rsp_q.push_back({8'h00, 1'b0, 1'b1});
      run_cmd("wb_err", 4'd4, 7'h10, 8'h09, 1'b1, 8'h00);
      err_at = 0;
   endtask

   task automatic test_reset_mid();
      bit ok, hit;
      int ready_at;
      $display("[TB] reset pulsed while polling");
      setup_slave(1, 0, 0, 0);
      tip_stuck = 1'b1;
      push_wr(7'h3B, 8'h20); push_wr(7'h3C, 8'h90); push_rd(7'h3C, 8);
      send_cmd(4'd7, 7'h10, 8'h00, 1'b0, 8'h00, ok);
      hit = 1'b0;
      for (int i = 0; i < 200 && ok; i++) begin
         @(negedge clk_i);
         if (sr_reads >= 2 && wb_cyc_o) begin
            hit = 1'b1;
            break;
         end
      end
      #2 rst_n_i = 1'b0;
      #1;
      n_cmp++;
      if (!hit || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_async_cyc: got polling=%0b cyc=%0b stb=%0b, required polling=1 cyc=0 stb=0",
                  hit, wb_cyc_o, wb_stb_o);
      end
      tip_stuck = 1'b0;
      exp_q.delete();
      push_init();
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
      ready_at = -1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk_i);
         if (cmd_ready_o) begin
            ready_at = i;
            break;
         end
      end
      n_cmp++;
      if (ready_at < 0 || exp_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL reinit_ready: got ready_cycle=%0d pending=%0d, required INIT rerun from bus 0",
                  ready_at, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_nack();
      test_timeout();
      test_bad_bus();
      test_retry();
      test_wb_err();
      test_reset_mid();
      test_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
